regfile_arbiter: RTL and testbench

Two-port access arbiter for the 8×8 register file (`reg8file`). It lets two independent requesters share the file's single write port and single read port. It runs a three-state sequencer that grants one transaction at a time, round-robin by default. It drives the register file's `wen`/`wsel`/`rsel`/`d` and returns read data and a one-cycle acknowledge to the winning requester.

---
 rtl/rfarb_pkg.sv | 10 +
 rtl/rr_pick2.sv | 27 ++
 rtl/regfile_arbiter.sv | 107 ++++++++++
 tb/tb_regfile_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rfarb_pkg.sv
// Shared constants for the register-file arbiter: sequencer state encoding
// and the data/address widths fixed by the 8x8 register file.
package rfarb_pkg;
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   localparam int RF_DW = 8;
   localparam int RF_AW = 3;
endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way picker. A lone requester always wins; on a tie the
// requester named by ptr wins (round-robin).
// Build option: RFARB_FIXED_PRIO_EN makes requester 0 win every tie and
// ignores ptr.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic       gnt,
   output logic       valid
);
`ifdef RFARB_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ptr;

   // requester 0 has absolute priority
   always_comb begin
      valid = |req;
      gnt   = ~req[0];
   end
`else
   // tie goes to ptr, otherwise whoever is asking
   always_comb begin
      valid = |req;
      gnt   = (&req) ? ptr : req[1];
   end
`endif
endmodule

// File: rtl/regfile_arbiter.sv
// Two-requester arbiter in front of the single-write/single-read 8x8
// register file. One transaction at a time: IDLE (sample) -> ACCESS (drive
// the file) -> RESP (ack), so a transaction occupies exactly three cycles.
// Build option: RFARB_FIXED_PRIO_EN selects fixed priority (requester 0)
// instead of round-robin; the priority pointer then becomes constant 0.
module regfile_arbiter
   import rfarb_pkg::*;
(
   input  logic             clk,
   input  logic             clrn,
   input  logic             req0,
   input  logic             req1,
   input  logic             we0,
   input  logic             we1,
   input  logic [RF_AW-1:0] addr0,
   input  logic [RF_AW-1:0] addr1,
   input  logic [RF_DW-1:0] wdata0,
   input  logic [RF_DW-1:0] wdata1,
   output logic             ack0,
   output logic             ack1,
   output logic [RF_DW-1:0] rdata0,
   output logic [RF_DW-1:0] rdata1,
   output logic             busy,
   output logic             rf_wen,
   output logic [RF_AW-1:0] rf_wsel,
   output logic [RF_AW-1:0] rf_rsel,
   output logic [RF_DW-1:0] rf_d,
   input  logic [RF_DW-1:0] rf_q
);
   logic [1:0]       state, state_nxt;
   logic             ptr;
   logic             pick_gnt, pick_vld;
   logic             op_win, op_we;
   logic [RF_AW-1:0] op_addr;
   logic [RF_DW-1:0] op_wdata;

   rr_pick2 u_pick (
      .req   ({req1, req0}),
      .ptr   (ptr),
      .gnt   (pick_gnt),
      .valid (pick_vld)
   );

   // state register
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // next state: requests only matter in IDLE, the rest is a fixed walk
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (pick_vld) state_nxt = S_ACCESS;
         S_ACCESS: state_nxt = S_RESP;
         S_RESP:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // latch the winner's operation so requesters may change inputs afterwards
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         op_win   <= 1'b0;
         op_we    <= 1'b0;
         op_addr  <= '0;
         op_wdata <= '0;
      end else if (state == S_IDLE && pick_vld) begin
         op_win   <= pick_gnt;
         op_we    <= pick_gnt ? we1    : we0;
         op_addr  <= pick_gnt ? addr1  : addr0;
         op_wdata <= pick_gnt ? wdata1 : wdata0;
      end
   end

   // capture read data for the winner at the end of ACCESS; writes leave it
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         rdata0 <= '0;
         rdata1 <= '0;
      end else if (state == S_ACCESS && !op_we) begin
         if (op_win) rdata1 <= rf_q;
         else        rdata0 <= rf_q;
      end
   end

`ifdef RFARB_FIXED_PRIO_EN
   assign ptr = 1'b0;
`else
   // hand the next tie to whoever lost this one
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn)                 ptr <= 1'b0;
      else if (state == S_RESP)  ptr <= ~op_win;
   end
`endif

   // outputs decoded from state and the latched op only
   always_comb begin
      busy    = (state != S_IDLE);
      rf_wen  = (state == S_ACCESS) && op_we;
      ack0    = (state == S_RESP) && !op_win;
      ack1    = (state == S_RESP) &&  op_win;
      rf_wsel = op_addr;
      rf_rsel = op_addr;
      rf_d    = op_wdata;
   end
endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: a stand-in 8x8 register file, a transaction
// level reference model checked every cycle, and directed scenarios with
// hand-computed expectations. Honours RFARB_FIXED_PRIO_EN if defined.
module tb_regfile_arbiter;
   logic       clk = 1'b0;
   logic       clrn = 1'b1;
   logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0;
   logic [2:0] addr0 = 0, addr1 = 0;
   logic [7:0] wdata0 = 0, wdata1 = 0;
   logic       ack0, ack1, busy, rf_wen;
   logic [7:0] rdata0, rdata1, rf_d, rf_q;
   logic [2:0] rf_wsel, rf_rsel;

   int n_tests = 0;
   int n_fail  = 0;

   regfile_arbiter dut (
      .clk(clk), .clrn(clrn),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .busy(busy), .rf_wen(rf_wen), .rf_wsel(rf_wsel), .rf_rsel(rf_rsel),
      .rf_d(rf_d), .rf_q(rf_q)
   );

   always #5 clk = ~clk;

   // stand-in register file: cleared by clrn, sync write, async read
   logic [7:0] rfm [8];
   always @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         for (int i = 0; i < 8; i++) rfm[i] <= 8'h00;
      end else if (rf_wen) begin
         rfm[rf_wsel] <= rf_d;
      end
   end
   assign rf_q = rfm[rf_rsel];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model: cycles since grant (0 none, 1 access, 2 ack), the
   // granted op, its own memory and the last read result per requester
   int         cyc = 0;
   bit         m_ptr = 0, m_win = 0, m_we = 0;
   logic [2:0] m_addr = 0;
   logic [7:0] m_wd = 0;
   logic [7:0] mmem [8] = '{default: 8'h00};
   logic [7:0] mrd  [2] = '{default: 8'h00};

   always @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         cyc = 0; m_ptr = 0; m_win = 0; m_we = 0; m_addr = 0; m_wd = 0;
         for (int i = 0; i < 8; i++) mmem[i] = 8'h00;
         mrd[0] = 8'h00; mrd[1] = 8'h00;
      end else if (cyc == 1) begin
         if (m_we) mmem[m_addr] = m_wd;
         else      mrd[m_win]   = mmem[m_addr];
         cyc = 2;
      end else if (cyc == 2) begin
`ifndef RFARB_FIXED_PRIO_EN
         m_ptr = !m_win;
`endif
         cyc = 0;
      end else if (req0 || req1) begin
         m_win  = (req0 && req1) ? m_ptr : req1;
         m_we   = m_win ? we1 : we0;
         m_addr = m_win ? addr1 : addr0;
         m_wd   = m_win ? wdata1 : wdata0;
         cyc    = 1;
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      chk("m_busy",   busy,    cyc != 0);
      chk("m_wen",    rf_wen,  cyc == 1 && m_we);
      chk("m_ack0",   ack0,    cyc == 2 && !m_win);
      chk("m_ack1",   ack1,    cyc == 2 &&  m_win);
      chk("m_rdata0", rdata0,  mrd[0]);
      chk("m_rdata1", rdata1,  mrd[1]);
      chk("m_wsel",   rf_wsel, m_addr);
      chk("m_rsel",   rf_rsel, m_addr);
      chk("m_d",      rf_d,    m_wd);
   end

   task automatic set_port(input int p, input bit r, input bit w, input logic [2:0] a, input logic [7:0] d);
      if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
      else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
   endtask

   // one transaction from an idle arbiter; called at posedge+2, returns at
   // posedge+2 with the arbiter idle again. scr scrambles inputs after grant.
   task automatic txn(input int p, input bit w, input logic [2:0] a, input logic [7:0] d,
                      input bit scr, output logic [7:0] rd);
      set_port(p, 1'b1, w, a, d);
      @(posedge clk); #2;
      if (scr) set_port(p, 1'b0, !w, a ^ 3'h2, d ^ 8'hFF);
      else     set_port(p, 1'b0, w, a, d);
      @(negedge clk);
      chk("lit_access_wen", rf_wen, w);
      chk("lit_access_busy", busy, 1);
      @(negedge clk);
      chk("lit_resp_wen", rf_wen, 0);
      chk("lit_ack_self",  p ? ack1 : ack0, 1);
      chk("lit_ack_other", p ? ack0 : ack1, 0);
      rd = p ? rdata1 : rdata0;
      @(posedge clk); #2;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ack0"}, ack0, 0);
      chk({tag, "_ack1"}, ack1, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_wen"},  rf_wen, 0);
      chk({tag, "_wsel"}, rf_wsel, 0);
      chk({tag, "_rsel"}, rf_rsel, 0);
      chk({tag, "_d"},    rf_d, 0);
      chk({tag, "_rd0"},  rdata0, 8'h00);
      chk({tag, "_rd1"},  rdata1, 8'h00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] rd;
      int         nacks, seq [4], at [4];
      int         first_win;
      logic [7:0] first_rd;

      // reset
      #3 clrn = 1'b0;
      #9 chk_reset_vals("rst");
      @(posedge clk); #2 clrn = 1'b1;

      // write A5 to r3, read it back through requester 0
      txn(0, 1, 3'd3, 8'hA5, 0, rd);
      txn(0, 0, 3'd3, 8'h00, 0, rd);
      chk("t1_rdata0", rd, 8'hA5);
      chk("t1_rdata1", rdata1, 8'h00);

      // preload r1/r2; last winner is requester 1 so the next tie goes to 0
      txn(0, 1, 3'd1, 8'h11, 0, rd);
      txn(1, 1, 3'd2, 8'h22, 0, rd);

      // both held: acks alternate, 3 cycles apart
      set_port(0, 1, 0, 3'd1, 8'h00);
      set_port(1, 1, 0, 3'd2, 8'h00);
      nacks = 0;
      for (int c = 0; c < 20 && nacks < 4; c++) begin
         @(negedge clk);
         if (ack0 || ack1) begin
            seq[nacks] = ack1 ? 1 : 0;
            at[nacks]  = c;
            nacks++;
            if (nacks == 4) begin req0 = 0; req1 = 0; end
         end
      end
      chk("t2_nacks", nacks, 4);
      if (nacks != 4) begin req0 = 0; req1 = 0; end
      @(posedge clk); #2;
`ifdef RFARB_FIXED_PRIO_EN
      chk("t2_seq0", seq[0], 0); chk("t2_seq1", seq[1], 0);
      chk("t2_seq2", seq[2], 0); chk("t2_seq3", seq[3], 0);
      chk("t2_rdata1", rdata1, 8'h00);
`else
      chk("t2_seq0", seq[0], 0); chk("t2_seq1", seq[1], 1);
      chk("t2_seq2", seq[2], 0); chk("t2_seq3", seq[3], 1);
      chk("t2_rdata1", rdata1, 8'h22);
`endif
      chk("t2_gap1", at[1] - at[0], 3);
      chk("t2_gap3", at[3] - at[2], 3);
      chk("t2_rdata0", rdata0, 8'h11);

      // simultaneous: 0 reads r5 (old value), 1 writes 3C to r5
      set_port(0, 1, 0, 3'd5, 8'h00);
      set_port(1, 1, 1, 3'd5, 8'h3C);
      nacks = 0; first_win = -1; first_rd = 8'hXX;
      for (int c = 0; c < 12 && nacks < 2; c++) begin
         @(negedge clk);
         if (ack0 || ack1) begin
            if (nacks == 0) begin first_win = ack1 ? 1 : 0; first_rd = rdata0; end
            if (ack0) req0 = 0;
            if (ack1) req1 = 0;
            nacks++;
         end
      end
      chk("t3_nacks", nacks, 2);
      req0 = 0; req1 = 0;
      @(posedge clk); #2;
      chk("t3_first_win", first_win, 0);
      chk("t3_old_val", first_rd, 8'h00);
      txn(0, 0, 3'd5, 8'h00, 0, rd);
      chk("t3_new_val", rd, 8'h3C);

      // reset during ACCESS of a write of FF to r7
      set_port(0, 1, 1, 3'd7, 8'hFF);
      @(posedge clk); #2 req0 = 0;
      #1 clrn = 1'b0;
      @(negedge clk);
      chk_reset_vals("midrst");
      #2 clrn = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("t4_no_ack0", ack0, 0);
         chk("t4_no_ack1", ack1, 0);
      end
      @(posedge clk); #2;
      txn(0, 0, 3'd7, 8'h00, 0, rd);
      chk("t4_r7", rd, 8'h00);

      // inputs scrambled after grant: latched op (write 5A to r4) must stand
      txn(1, 1, 3'd4, 8'h5A, 1, rd);
      txn(0, 0, 3'd4, 8'h00, 0, rd);
      chk("t5_r4", rd, 8'h5A);
      txn(0, 0, 3'd6, 8'h00, 0, rd);
      chk("t5_r6", rd, 8'h00);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
